// File: rtl/dbus_axi_bridge_pkg.sv
// rtl/dbus_axi_bridge_pkg.sv - shared types and AXI constants for the data-bus AXI bridge
package dbus_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RADDR,
    ST_RDATA,
    ST_WADDR,
    ST_WRESP,
    ST_DONE
  } state_t;

  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // SLVERR and DECERR are the only error responses; EXOKAY counts as success.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/dbus_axi_bridge_if.sv
// rtl/dbus_axi_bridge_if.sv - single-beat AXI4 read/write channels between bridge and slave
interface dbus_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [3:0]          arid;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  logic [3:0]          awid;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, arlen, arsize, araddr, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready,
    output awid, awlen, awsize, awaddr, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, arlen, arsize, araddr, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready,
    input  awid, awlen, awsize, awaddr, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/dbus_axi_bridge.sv
// rtl/dbus_axi_bridge.sv - CPU data-bus request to single-beat AXI4 bridge, one transaction in flight
module dbus_axi_bridge
  import dbus_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_w,
  output logic [DATA_W-1:0] data_r,
  output logic              stall,
  output logic              bus_err,
  dbus_axi_bridge_if.master axi
);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              aw_done;
  logic              w_done;
  logic              orphan;

  logic arvalid_c, rready_c, awvalid_c, wvalid_c, bready_c;
  logic xfer_end;
  logic discard;
  logic busy;
  logic aw_hs, w_hs;

  assign aw_hs = awvalid_c && axi.awready;
  assign w_hs  = wvalid_c && axi.wready;
  assign busy  = (state == ST_RADDR) || (state == ST_RDATA) ||
                 (state == ST_WADDR) || (state == ST_WRESP);

  // A flush seen in the completing cycle discards the result just like an earlier one.
  assign discard = orphan || !en;

  assign stall = en && (state != ST_DONE);

  always_comb begin
    state_nxt = state;
    arvalid_c = 1'b0;
    rready_c  = 1'b0;
    awvalid_c = 1'b0;
    wvalid_c  = 1'b0;
    bready_c  = 1'b0;
    xfer_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = (we == 4'd0) ? ST_RADDR : ST_WADDR;
      end
      ST_RADDR: begin
        arvalid_c = 1'b1;
        if (axi.arready) state_nxt = ST_RDATA;
      end
      ST_RDATA: begin
        rready_c = 1'b1;
        xfer_end = axi.rvalid;
      end
      ST_WADDR: begin
        awvalid_c = !aw_done;
        wvalid_c  = !w_done;
        if ((aw_done || axi.awready) && (w_done || axi.wready)) state_nxt = ST_WRESP;
      end
      ST_WRESP: begin
        bready_c = 1'b1;
        xfer_end = axi.bvalid;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (xfer_end) state_nxt = discard ? ST_IDLE : ST_DONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      orphan  <= 1'b0;
      data_r  <= '0;
      bus_err <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == ST_IDLE && en) begin
        addr_q  <= addr;
        we_q    <= we;
        wdata_q <= data_w;
      end

      if (state == ST_WADDR) begin
        if (state_nxt == ST_WRESP) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
      end

      // The AXI side always runs to completion; orphan only suppresses the result.
      if (busy && !en) orphan <= 1'b1;
      if (state_nxt == ST_IDLE) orphan <= 1'b0;

      if (xfer_end && !discard) begin
        if (state == ST_RDATA) begin
          data_r  <= axi.rdata;
          bus_err <= resp_is_err(axi.rresp);
        end else begin
          bus_err <= resp_is_err(axi.bresp);
        end
      end else if (state == ST_DONE) begin
        bus_err <= 1'b0;
      end
    end
  end

  assign axi.arid    = AXI_ID;
  assign axi.arlen   = AXI_LEN_SINGLE;
  assign axi.arsize  = AXI_SIZE_4B;
  assign axi.araddr  = addr_q;
  assign axi.arvalid = arvalid_c;
  assign axi.rready  = rready_c;

  assign axi.awid    = AXI_ID;
  assign axi.awlen   = AXI_LEN_SINGLE;
  assign axi.awsize  = AXI_SIZE_4B;
  assign axi.awaddr  = addr_q;
  assign axi.awvalid = awvalid_c;

  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = we_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_c;
  assign axi.bready  = bready_c;

endmodule

// File: tb/tb_dbus_axi_bridge.sv
// tb/tb_dbus_axi_bridge.sv - self-checking bench for dbus_axi_bridge with a reactive AXI slave
module tb_dbus_axi_bridge;
  import dbus_axi_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  we = 4'd0;
  logic [31:0] addr = '0;
  logic [31:0] data_w = '0;
  logic [31:0] data_r;
  logic        stall;
  logic        bus_err;

  always #5 clk = ~clk;

  dbus_axi_bridge_if axi ();

  dbus_axi_bridge #(.AXI_ID(4'd1), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .data_w(data_w),
    .data_r(data_r), .stall(stall), .bus_err(bus_err), .axi(axi)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave timing knobs: cycles a valid waits before ready, or before a response appears.
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [1:0] bresp_cfg = RESP_OKAY;
  typedef struct { logic [31:0] data; logic [1:0] resp; } rbeat_t;
  rbeat_t rq[$];

  // Behavioural expectations
  logic        exp_stall = 1'b0;
  logic [31:0] exp_data_r = '0;
  logic        exp_bus_err = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;
  int stall_hi = 0, bus_err_hi = 0, ar_hs_n = 0, aw_hs_n = 0, w_hs_n = 0;
  logic aw_taken = 1'b0, w_taken = 1'b0;

  // Reactive AXI slave
  initial begin
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit r_pend, b_pend, aw_seen, w_seen;
    bit s_ar, s_r, s_aw, s_w, s_b;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = '0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = '0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
    forever begin
      @(negedge clk);
      s_ar = axi.arvalid && axi.arready;
      s_r  = axi.rvalid && axi.rready;
      s_aw = axi.awvalid && axi.awready;
      s_w  = axi.wvalid && axi.wready;
      s_b  = axi.bvalid && axi.bready;
      @(posedge clk);
      #1;
      if (!rst) begin
        axi.arready = 0; axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
      end else begin
        if (s_ar) begin axi.arready = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0; end
        else if (axi.arvalid) begin axi.arready = (ar_cnt >= ar_wait); ar_cnt++; end
        if (s_r) begin
          axi.rvalid = 0; r_pend = 0;
          if (rq.size() > 0) void'(rq.pop_front());
        end else if (r_pend && !axi.rvalid) begin
          if (r_cnt >= r_wait && rq.size() > 0) begin
            axi.rvalid = 1; axi.rdata = rq[0].data; axi.rresp = rq[0].resp;
          end
          r_cnt++;
        end
        if (s_aw) begin axi.awready = 0; aw_cnt = 0; aw_seen = 1; end
        else if (axi.awvalid) begin axi.awready = (aw_cnt >= aw_wait); aw_cnt++; end
        if (s_w) begin axi.wready = 0; w_cnt = 0; w_seen = 1; end
        else if (axi.wvalid) begin axi.wready = (w_cnt >= w_wait); w_cnt++; end
        if (aw_seen && w_seen) begin b_pend = 1; b_cnt = 0; aw_seen = 0; w_seen = 0; end
        if (s_b) begin axi.bvalid = 0; b_pend = 0; end
        else if (b_pend && !axi.bvalid) begin
          if (b_cnt >= b_wait) begin axi.bvalid = 1; axi.bresp = bresp_cfg; end
          b_cnt++;
        end
      end
    end
  end

  // Per-cycle compare against the model and the AXI rules
  logic p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
  logic [31:0] p_araddr = '0, p_awaddr = '0, p_wdata = '0;
  always @(negedge clk) begin
    if (rst) begin
      chk("const_ar", {axi.arid, axi.arlen, axi.arsize}, {17'd0, 4'd1, 8'd0, 3'b010});
      chk("const_aw", {axi.awid, axi.awlen, axi.awsize, axi.wlast}, {16'd0, 4'd1, 8'd0, 3'b010, 1'b1});
      chk("stall", stall, exp_stall);
      chk("data_r", data_r, exp_data_r);
      chk("bus_err", bus_err, exp_bus_err);
      if (stall) stall_hi++;
      if (bus_err) bus_err_hi++;
      if (axi.arvalid && axi.arready) begin ar_hs_n++; chk("araddr", axi.araddr, exp_addr); end
      if (axi.awvalid && aw_taken) chk("awvalid_again", axi.awvalid, 1'b0);
      if (axi.wvalid && w_taken) chk("wvalid_again", axi.wvalid, 1'b0);
      if (axi.awvalid && axi.awready) begin aw_hs_n++; chk("awaddr", axi.awaddr, exp_addr); aw_taken = 1; end
      if (axi.wvalid && axi.wready) begin
        w_hs_n++; w_taken = 1;
        chk("wdata", axi.wdata, exp_wdata);
        chk("wstrb", {28'd0, axi.wstrb}, {28'd0, exp_wstrb});
      end
      if (p_arv && !p_arr) chk("ar_stable", {axi.arvalid, axi.araddr}, {1'b1, p_araddr});
      if (p_awv && !p_awr) chk("aw_stable", {axi.awvalid, axi.awaddr}, {1'b1, p_awaddr});
      if (p_wv && !p_wr) chk("w_stable", {axi.wvalid, axi.wdata}, {1'b1, p_wdata});
      p_arv = axi.arvalid; p_arr = axi.arready; p_araddr = axi.araddr;
      p_awv = axi.awvalid; p_awr = axi.awready; p_awaddr = axi.awaddr;
      p_wv = axi.wvalid; p_wr = axi.wready; p_wdata = axi.wdata;
    end else begin
      p_arv = 0; p_awv = 0; p_wv = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    exp_bus_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      en = 0; we = 0; exp_stall = 0;
    end
  endtask

  // Read: w1=ar wait, w2=r wait. Write: w1=aw wait, w2=w wait, w3=b wait.
  task automatic run_req(input bit wr, input logic [31:0] a, input logic [3:0] strb,
                         input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] resp,
                         input int w1, input int w2, input int w3);
    int lat;
    if (wr) begin
      aw_wait = w1; w_wait = w2; b_wait = w3; bresp_cfg = resp;
      lat = 3 + ((w1 > w2) ? w1 : w2) + w3;
    end else begin
      ar_wait = w1; r_wait = w2;
      rq.push_back('{rd, resp});
      lat = 3 + w1 + w2;
    end
    for (int c = 0; c <= lat; c++) begin
      tick();
      if (c == 0) begin
        en = 1; we = wr ? strb : 4'd0; addr = a; data_w = wd;
        exp_addr = a; exp_wdata = wd; exp_wstrb = strb;
        aw_taken = 0; w_taken = 0;
      end
      exp_stall = (c != lat);
      if (c == lat) begin
        if (!wr) exp_data_r = rd;
        exp_bus_err = resp[1];
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 5'b0);
    chk("rst_data_r", data_r, 32'h0);
    chk("rst_bus_err", bus_err, 1'b0);
    rst = 1;
    idle(2);

    // Read with waits: 7 stall cycles
    stall_hi = 0; ar_hs_n = 0;
    run_req(0, 32'h1000, 4'd0, 32'h0, 32'hDEADBEEF, RESP_OKAY, 2, 2, 0);
    idle(1);
    chk("t1_stall_cycles", stall_hi, 7);
    chk("t1_data_r", data_r, 32'hDEADBEEF);
    chk("t1_ar_hs", ar_hs_n, 1);

    // Write, W before AW, B after one wait
    stall_hi = 0; aw_hs_n = 0; w_hs_n = 0;
    run_req(1, 32'h2004, 4'b0011, 32'h12345678, 32'h0, RESP_OKAY, 2, 0, 1);
    idle(1);
    chk("t2_stall_cycles", stall_hi, 6);
    chk("t2_aw_hs", aw_hs_n, 1);
    chk("t2_w_hs", w_hs_n, 1);
    chk("t2_data_r_kept", data_r, 32'hDEADBEEF);

    // Error responses
    bus_err_hi = 0;
    run_req(0, 32'h1004, 4'd0, 32'h0, 32'hCAFEF00D, RESP_SLVERR, 0, 1, 0);
    idle(1);
    chk("t3_bus_err_cycles", bus_err_hi, 1);
    chk("t3_data_r", data_r, 32'hCAFEF00D);
    bus_err_hi = 0; aw_hs_n = 0; w_hs_n = 0;
    run_req(1, 32'h2008, 4'b1111, 32'h55AA33CC, 32'h0, RESP_DECERR, 1, 1, 0);
    idle(1);
    chk("t3w_bus_err_cycles", bus_err_hi, 1);
    chk("t3w_hs", aw_hs_n + w_hs_n, 2);

    // Flush during RDATA, new read waits for the orphan to drain
    ar_hs_n = 0; bus_err_hi = 0;
    ar_wait = 0; r_wait = 4;
    rq.push_back('{32'h0BADF00D, RESP_SLVERR});
    rq.push_back('{32'h33333333, RESP_OKAY});
    for (int c = 0; c <= 10; c++) begin
      tick();
      if (c == 0) begin en = 1; we = 0; addr = 32'h2000; exp_addr = 32'h2000; end
      if (c == 3) en = 0;
      if (c == 4) begin en = 1; addr = 32'h3000; end
      if (c == 7) begin r_wait = 0; exp_addr = 32'h3000; end
      exp_stall = en && (c != 10);
      if (c == 10) exp_data_r = 32'h33333333;
    end
    idle(1);
    chk("t4_ar_hs", ar_hs_n, 2);
    chk("t4_bus_err_cycles", bus_err_hi, 0);
    chk("t4_data_r", data_r, 32'h33333333);

    // Back-to-back zero-wait reads
    stall_hi = 0;
    run_req(0, 32'h0010, 4'd0, 32'h0, 32'h0000000A, RESP_OKAY, 0, 0, 0);
    chk("t5_first", data_r, 32'h0000000A);
    run_req(0, 32'h0014, 4'd0, 32'h0, 32'h0000000B, RESP_OKAY, 0, 0, 0);
    idle(1);
    chk("t5_stall_cycles", stall_hi, 6);
    chk("t5_second", data_r, 32'h0000000B);

    // Asynchronous reset in the middle of WADDR
    aw_wait = 5; w_wait = 5; b_wait = 0;
    tick();
    en = 1; we = 4'hF; addr = 32'h5000; data_w = 32'h01020304;
    exp_addr = 32'h5000; exp_wdata = 32'h01020304; exp_wstrb = 4'hF;
    aw_taken = 0; w_taken = 0; exp_stall = 1;
    tick();
    tick();
    chk("t6_pre_valids", {axi.awvalid, axi.wvalid}, 2'b11);
    #2;
    rst = 0;
    #1;
    chk("t6_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 5'b0);
    chk("t6_data_r", data_r, 32'h0);
    en = 0; we = 0; exp_stall = 0; exp_data_r = 32'h0;
    tick();
    tick();
    rst = 1;
    idle(1);
    ar_hs_n = 0;
    run_req(0, 32'h6000, 4'd0, 32'h0, 32'h0000600D, RESP_OKAY, 1, 0, 0);
    idle(2);
    chk("t6_after_read", data_r, 32'h0000600D);
    chk("t6_ar_hs", ar_hs_n, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
